// File: rtl/option_dispatcher.sv
// ---------------------------------------------------------------------------
// option_dispatcher
//
// Host-side issuing/collecting end of the Monte Carlo pricing top.
//   * Accepts tagged option requests (mu, s, sigma) on a valid/ready stream,
//     latches the parameters, and sends a one-cycle o_new_option pulse.
//   * Enforces a minimum spacing of ISSUE_GAP+1 clocks between accepts, so
//     the pricing top can keep consuming the held parameters.
//   * Keeps the outstanding tags in a DEPTH-entry FIFO. Each i_core_done
//     retires the oldest tag and returns it with i_acc1 + i_acc2 on a
//     valid/ready result stream.
//
// Ports
//   clk, rst_n                    clock, async active-low reset
//   i_opt_valid / o_opt_ready     request handshake
//   i_opt_tag/_mu/_s/_sigma       request payload
//   o_new_option                  one-cycle start pulse to the pricing top
//   o_mu / o_s / o_sigma          held parameters to the pricing top
//   i_core_done, i_acc1, i_acc2   completion pulse and the two core prices
//   o_res_valid / i_res_ready     result handshake
//   o_res_tag, o_res_price        result payload (price is ACC_W+1 bits)
//   o_inflight                    outstanding option count
//   o_overrun                     sticky: a result was dropped (register held)
//   o_spurious                    sticky: a done arrived with nothing in flight
// ---------------------------------------------------------------------------
module option_dispatcher #(
    parameter int TAG_W     = 4,
    parameter int DEPTH     = 4,
    parameter int ISSUE_GAP = 80,
    parameter int ACC_W     = 23
) (
    input  logic                       clk,
    input  logic                       rst_n,

    input  logic                       i_opt_valid,
    output logic                       o_opt_ready,
    input  logic [TAG_W-1:0]           i_opt_tag,
    input  logic [17:0]                i_opt_mu,
    input  logic [16:0]                i_opt_s,
    input  logic [17:0]                i_opt_sigma,

    output logic                       o_new_option,
    output logic [17:0]                o_mu,
    output logic [16:0]                o_s,
    output logic [17:0]                o_sigma,

    input  logic                       i_core_done,
    input  logic [ACC_W-1:0]           i_acc1,
    input  logic [ACC_W-1:0]           i_acc2,

    output logic                       o_res_valid,
    input  logic                       i_res_ready,
    output logic [TAG_W-1:0]           o_res_tag,
    output logic [ACC_W:0]             o_res_price,

    output logic [$clog2(DEPTH):0]     o_inflight,
    output logic                       o_overrun,
    output logic                       o_spurious
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int GAP_W = $clog2(ISSUE_GAP);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_GAP  = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_t             r_state;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic               r_opt_ready;
    logic               r_new_option;
    logic [17:0]        r_mu;
    logic [16:0]        r_s;
    logic [17:0]        r_sigma;

    logic [TAG_W-1:0]   r_tag_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_inflight;

    logic               r_res_valid;
    logic [TAG_W-1:0]   r_res_tag;
    logic [ACC_W:0]     r_res_price;
    logic               r_overrun;
    logic               r_spurious;

    // -----------------------------------------------------------------------
    // Combinational next-state
    // -----------------------------------------------------------------------
    state_t             w_state_nxt;
    logic [GAP_W-1:0]   w_gap_nxt;
    logic               w_accept;
    logic               w_empty;
    logic               w_pop;
    logic [CNT_W-1:0]   w_inflight_nxt;
    logic               w_ready_nxt;
    logic               w_res_load;
    logic [ACC_W:0]     w_price;

    // r_opt_ready is only ever set while the next state is IDLE, so it
    // already qualifies the accept without looking at r_state here.
    assign w_accept = i_opt_valid && r_opt_ready;
    assign w_empty  = (r_inflight == '0);
    assign w_pop    = i_core_done && !w_empty;

    // A pop may free the result register in the same edge it is loaded.
    assign w_res_load = w_pop && (!r_res_valid || i_res_ready);
    assign w_price    = {1'b0, i_acc1} + {1'b0, i_acc2};

    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_GAP;
                    w_gap_nxt   = GAP_W'(ISSUE_GAP - 1);
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gap_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_inflight_nxt = r_inflight;
        case ({w_accept, w_pop})
            2'b10:   w_inflight_nxt = r_inflight + 1'b1;
            2'b01:   w_inflight_nxt = r_inflight - 1'b1;
            default: w_inflight_nxt = r_inflight;
        endcase
    end

    // Ready is registered from next-state values: no input reaches it
    // combinationally, and a pop while full raises it one cycle later.
    assign w_ready_nxt = (w_state_nxt == ST_IDLE) &&
                         (w_inflight_nxt < CNT_W'(DEPTH));

    // -----------------------------------------------------------------------
    // Issue side: FSM, gap counter, held parameters, start pulse
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_gap_cnt    <= '0;
            r_opt_ready  <= 1'b0;
            r_new_option <= 1'b0;
            r_mu         <= '0;
            r_s          <= '0;
            r_sigma      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_gap_cnt    <= w_gap_nxt;
            r_opt_ready  <= w_ready_nxt;
            r_new_option <= w_accept;
            if (w_accept) begin
                r_mu    <= i_opt_mu;
                r_s     <= i_opt_s;
                r_sigma <= i_opt_sigma;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Tag FIFO. Storage needs no reset; the pointers and count define
    // which entries are live.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_tag_mem[r_wr_ptr] <= i_opt_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_inflight <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
            r_inflight <= w_inflight_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Collect side: result register and sticky error flags
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_tag   <= '0;
            r_res_price <= '0;
            r_overrun   <= 1'b0;
            r_spurious  <= 1'b0;
        end else begin
            if (w_res_load) begin
                r_res_valid <= 1'b1;
                r_res_tag   <= r_tag_mem[r_rd_ptr];
                r_res_price <= w_price;
            end else if (i_res_ready) begin
                r_res_valid <= 1'b0;
            end

            // Held result wins; the newly completed one is dropped.
            if (w_pop && !w_res_load) begin
                r_overrun <= 1'b1;
            end
            if (i_core_done && w_empty) begin
                r_spurious <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign o_opt_ready  = r_opt_ready;
    assign o_new_option = r_new_option;
    assign o_mu         = r_mu;
    assign o_s          = r_s;
    assign o_sigma      = r_sigma;
    assign o_res_valid  = r_res_valid;
    assign o_res_tag    = r_res_tag;
    assign o_res_price  = r_res_price;
    assign o_inflight   = r_inflight;
    assign o_overrun    = r_overrun;
    assign o_spurious   = r_spurious;

endmodule

// File: tb/tb_option_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_option_dispatcher
//
// Directed scenarios followed by random traffic. A transaction-level model
// (queue of outstanding tags, elapsed-clock count since the last accept)
// predicts every output once per cycle; outputs are sampled on the falling
// edge and inputs are driven there too.
// ---------------------------------------------------------------------------
module tb_option_dispatcher;

    localparam int TAG_W = 4;
    localparam int DEPTH = 2;
    localparam int GAP   = 8;
    localparam int ACC_W = 23;

    logic                   clk;
    logic                   rst_n;
    logic                   i_opt_valid;
    logic                   o_opt_ready;
    logic [TAG_W-1:0]       i_opt_tag;
    logic [17:0]            i_opt_mu;
    logic [16:0]            i_opt_s;
    logic [17:0]            i_opt_sigma;
    logic                   o_new_option;
    logic [17:0]            o_mu;
    logic [16:0]            o_s;
    logic [17:0]            o_sigma;
    logic                   i_core_done;
    logic [ACC_W-1:0]       i_acc1;
    logic [ACC_W-1:0]       i_acc2;
    logic                   o_res_valid;
    logic                   i_res_ready;
    logic [TAG_W-1:0]       o_res_tag;
    logic [ACC_W:0]         o_res_price;
    logic [$clog2(DEPTH):0] o_inflight;
    logic                   o_overrun;
    logic                   o_spurious;

    option_dispatcher #(
        .TAG_W(TAG_W), .DEPTH(DEPTH), .ISSUE_GAP(GAP), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_opt_valid(i_opt_valid), .o_opt_ready(o_opt_ready),
        .i_opt_tag(i_opt_tag), .i_opt_mu(i_opt_mu), .i_opt_s(i_opt_s),
        .i_opt_sigma(i_opt_sigma),
        .o_new_option(o_new_option), .o_mu(o_mu), .o_s(o_s), .o_sigma(o_sigma),
        .i_core_done(i_core_done), .i_acc1(i_acc1), .i_acc2(i_acc2),
        .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
        .o_res_tag(o_res_tag), .o_res_price(o_res_price),
        .o_inflight(o_inflight), .o_overrun(o_overrun), .o_spurious(o_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ----------------------------- counters -------------------------------
    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int nopt_cyc[$];

    // ----------------------------- model ----------------------------------
    logic [TAG_W-1:0] q[$];
    int               since;
    bit               m_ready, m_newopt, m_rv, m_ovr, m_spur;
    logic [TAG_W-1:0] m_tag;
    logic [ACC_W:0]   m_price;
    logic [17:0]      m_mu, m_sigma;
    logic [16:0]      m_s;

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", nm, obs, exp);
    endtask

    task automatic check_all();
        chk("opt_ready",  32'(o_opt_ready),  32'(m_ready));
        chk("new_option", 32'(o_new_option), 32'(m_newopt));
        chk("mu",         32'(o_mu),         32'(m_mu));
        chk("s",          32'(o_s),          32'(m_s));
        chk("sigma",      32'(o_sigma),      32'(m_sigma));
        chk("res_valid",  32'(o_res_valid),  32'(m_rv));
        chk("res_tag",    32'(o_res_tag),    32'(m_tag));
        chk("res_price",  32'(o_res_price),  32'(m_price));
        chk("inflight",   32'(o_inflight),   32'(q.size()));
        chk("overrun",    32'(o_overrun),    32'(m_ovr));
        chk("spurious",   32'(o_spurious),   32'(m_spur));
    endtask

    task automatic model_reset();
        q.delete();
        since    = 1000;
        m_ready  = 0; m_newopt = 0; m_rv = 0; m_ovr = 0; m_spur = 0;
        m_tag    = '0; m_price = '0;
        m_mu     = '0; m_s = '0; m_sigma = '0;
    endtask

    // One clock: predict the effect of the current inputs, clock, check.
    task automatic step();
        bit acc;
        bit load;
        logic [TAG_W-1:0] t;
        acc  = i_opt_valid && m_ready;
        load = 0;
        if (i_core_done) begin
            if (q.size() == 0) begin
                m_spur = 1;
            end else begin
                t = q.pop_front();
                if (!m_rv || i_res_ready) begin
                    load    = 1;
                    m_tag   = t;
                    m_price = (ACC_W+1)'(i_acc1) + (ACC_W+1)'(i_acc2);
                end else begin
                    m_ovr = 1;
                end
            end
        end
        if (load)             m_rv = 1;
        else if (i_res_ready) m_rv = 0;
        m_newopt = acc;
        if (acc) begin
            q.push_back(i_opt_tag);
            m_mu = i_opt_mu; m_s = i_opt_s; m_sigma = i_opt_sigma;
            since = 0;
        end else if (since < 1000) begin
            since++;
        end
        m_ready = (since >= GAP) && (q.size() < DEPTH);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (o_new_option) nopt_cyc.push_back(cyc);
        check_all();
    endtask

    task automatic clear_inputs();
        i_opt_valid = 0; i_opt_tag = '0; i_opt_mu = '0; i_opt_s = '0;
        i_opt_sigma = '0; i_core_done = 0; i_acc1 = '0; i_acc2 = '0;
        i_res_ready = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst_n = 0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1;
        check_all();
    endtask

    // Hold a request valid until the model says it is taken (bounded).
    task automatic accept_one(input logic [TAG_W-1:0] tag, input logic [17:0] mu,
                              input logic [16:0] s, input logic [17:0] sig);
        bit done_acc;
        done_acc = 0;
        i_opt_valid = 1; i_opt_tag = tag; i_opt_mu = mu; i_opt_s = s; i_opt_sigma = sig;
        for (int k = 0; k < 40 && !done_acc; k++) begin
            done_acc = m_ready;
            step();
        end
        if (!done_acc) chk("accept_timeout", 32'd0, 32'd1);
        i_opt_valid = 0;
    endtask

    task automatic pulse_done(input logic [ACC_W-1:0] a1, input logic [ACC_W-1:0] a2);
        i_core_done = 1; i_acc1 = a1; i_acc2 = a2;
        step();
        i_core_done = 0;
    endtask

    // ----------------------------- stimulus --------------------------------
    initial begin
        clear_inputs();
        rst_n = 0;
        model_reset();
        repeat (2) @(negedge clk);

        // 1. single request, sum check
        do_reset();
        step();
        accept_one(4'd3, 18'h00800, 17'h05000, 18'h01000);
        chk("t1_new_option", 32'(o_new_option), 32'd1);
        chk("t1_mu", 32'(o_mu), 32'h00800);
        repeat (3) step();
        chk("t1_params_held", 32'(o_s), 32'h05000);
        i_res_ready = 0;
        pulse_done(23'h100000, 23'h0FFFFF);
        chk("t1_res_valid", 32'(o_res_valid), 32'd1);
        chk("t1_res_tag", 32'(o_res_tag), 32'd3);
        chk("t1_res_price", 32'(o_res_price), 32'h1FFFFF);
        i_res_ready = 1;
        step();
        chk("t1_res_cleared", 32'(o_res_valid), 32'd0);

        // 2. back-to-back requests: spacing and full stall
        do_reset();
        nopt_cyc.delete();
        i_res_ready = 1;
        i_opt_valid = 1; i_opt_tag = 4'd1;
        for (int k = 0; k < 30; k++) begin
            step();
            if (o_new_option) i_opt_tag = i_opt_tag + 1'b1;
        end
        chk("t2_accepts", 32'(nopt_cyc.size()), 32'd2);
        if (nopt_cyc.size() >= 2)
            chk("t2_spacing", 32'(nopt_cyc[1] - nopt_cyc[0]), 32'(GAP + 1));
        chk("t2_full_ready", 32'(o_opt_ready), 32'd0);
        chk("t2_full_inflight", 32'(o_inflight), 32'd2);
        pulse_done(23'd10, 23'd20);
        chk("t2_ready_after_done", 32'(o_opt_ready), 32'd1);
        chk("t2_first_tag", 32'(o_res_tag), 32'd1);
        step();
        chk("t2_third_issued", 32'(o_new_option), 32'd1);
        i_opt_valid = 0;
        repeat (2) step();

        // 3. overrun: tags 5 and 6, result never drained
        do_reset();
        step();
        accept_one(4'd5, 18'h1, 17'h1, 18'h1);
        accept_one(4'd6, 18'h2, 17'h2, 18'h2);
        i_res_ready = 0;
        pulse_done(23'd100, 23'd1);
        pulse_done(23'd200, 23'd2);
        chk("t3_held_tag", 32'(o_res_tag), 32'd5);
        chk("t3_held_price", 32'(o_res_price), 32'd101);
        chk("t3_overrun", 32'(o_overrun), 32'd1);
        chk("t3_inflight", 32'(o_inflight), 32'd0);

        // 4. spurious done with nothing in flight
        i_res_ready = 1;
        step();
        pulse_done(23'd7, 23'd7);
        chk("t4_spurious", 32'(o_spurious), 32'd1);
        chk("t4_no_result", 32'(o_res_valid), 32'd0);

        // 5. maximum accumulators
        accept_one(4'd9, 18'h3FFFF, 17'h1FFFF, 18'h3FFFF);
        pulse_done(23'h7FFFFF, 23'h7FFFFF);
        chk("t5_max_price", 32'(o_res_price), 32'hFFFFFE);
        step();

        // 6. reset with work outstanding and a result pending
        do_reset();
        step();
        accept_one(4'd2, 18'h11, 17'h22, 18'h33);
        accept_one(4'd4, 18'h44, 17'h55, 18'h66);
        i_res_ready = 0;
        pulse_done(23'd5, 23'd6);
        accept_one(4'd8, 18'h77, 17'h88, 18'h99);
        chk("t6_pre_inflight", 32'(o_inflight), 32'd2);
        chk("t6_pre_valid", 32'(o_res_valid), 32'd1);
        do_reset();
        chk("t6_post_inflight", 32'(o_inflight), 32'd0);
        chk("t6_post_valid", 32'(o_res_valid), 32'd0);
        chk("t6_post_mu", 32'(o_mu), 32'd0);
        step();
        pulse_done(23'd1, 23'd1);
        chk("t6_spurious", 32'(o_spurious), 32'd1);

        // 7. random traffic
        do_reset();
        for (int k = 0; k < 1200; k++) begin
            i_opt_valid = 1'($urandom_range(0, 1));
            i_opt_tag   = TAG_W'($urandom);
            i_opt_mu    = 18'($urandom);
            i_opt_s     = 17'($urandom);
            i_opt_sigma = 18'($urandom);
            i_core_done = ($urandom_range(0, 7) == 0);
            i_acc1      = ACC_W'($urandom);
            i_acc2      = ACC_W'($urandom);
            i_res_ready = ($urandom_range(0, 2) != 0);
            step();
            if (k == 600) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/option_dispatcher.md
Name: option_dispatcher

Overview:
Host-side driver for the Monte Carlo pricing top. It accepts tagged option requests (mu, s, sigma) over a valid/ready stream and drives the top's new-option pulse with stable parameters. It then matches each core-done pulse to the oldest outstanding request and returns the tag with the summed two-core price over a valid/ready result stream. It sits between the host/request FIFO and the pricing top, as the issuing and collecting end of that interface.

Parameters:
TAG_W, 4, width of the request tag carried through to the result
DEPTH, 4, maximum outstanding options (tag FIFO depth); power of two, at least 2
ISSUE_GAP, 80, minimum clocks between successive o_new_option pulses; covers ExpMu/ExpSigma consumption of held parameters; at least 2
ACC_W, 23, width of each core accumulator output

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_opt_valid  in  1  request valid
o_opt_ready  out  1  request ready
i_opt_tag  in  TAG_W  request tag
i_opt_mu  in  18  drift, 18 fractional bits
i_opt_s  in  17  spot, 6 integer / 11 fractional bits
i_opt_sigma  in  18  volatility, 18 fractional bits
o_new_option  out  1  one-cycle pulse to the pricing top
o_mu / o_s / o_sigma  out  18/17/18  held parameters to the pricing top
i_core_done  in  1  core-0 done pulse from the pricing top
i_acc1 / i_acc2  in  ACC_W each  core price outputs, valid in the i_core_done cycle
o_res_valid  out  1  result valid
i_res_ready  in  1  result ready
o_res_tag  out  TAG_W  tag of the completed option
o_res_price  out  ACC_W+1  i_acc1 + i_acc2, zero-extended, no overflow
o_inflight  out  log2(DEPTH)+1  outstanding option count
o_overrun  out  1  sticky: a done arrived while the result register was still full
o_spurious  out  1  sticky: a done arrived with no outstanding option

Behaviour:
- Reset (async, rst_n low): all outputs 0, tag FIFO empty, gap counter 0, FSM in IDLE. Reset mid-operation discards outstanding tags and any pending result.
- FSM states:
  - IDLE: o_opt_ready = (inflight < DEPTH).
  - GAP: o_opt_ready = 0; counter runs ISSUE_GAP-1 down to 0, then returns to IDLE.
- Accept: on a clock edge with valid && ready:
  - load o_mu/o_s/o_sigma and push the tag;
  - o_new_option goes high for exactly the next cycle;
  - enter GAP.
  - Parameters stay stable until the next accept.
  - Accept-to-accept spacing is at least ISSUE_GAP+1 clocks.
- Collect: on an edge with i_core_done:
  - If FIFO empty: set o_spurious and change nothing else.
  - Otherwise pop the head tag.
  - If the result register is free, or i_res_ready is high that same cycle: load o_res_tag, load o_res_price = i_acc1 + i_acc2, and set o_res_valid the next cycle.
  - If the result register is held (valid && !ready): keep the held result unchanged, drop the new one, set o_overrun.
- Result handshake: o_res_valid and its data stay stable until an edge with i_res_ready. o_res_valid clears on that edge unless a new done loads it in the same edge.
- Push and pop on the same edge: inflight unchanged, FIFO pointers both advance and wrap modulo DEPTH.
- Full: inflight == DEPTH forces o_opt_ready low even in IDLE. A pop in the same cycle does not raise ready combinationally; ready rises the next cycle.
- Sticky flags clear only on reset.
- Timing:
  - accept-to-o_new_option latency is 1 clock;
  - done-to-o_res_valid latency is 1 clock;
  - no combinational path from any input to o_opt_ready or o_res_valid.

Test Plan:
- Reset then single request (ISSUE_GAP=8, DEPTH=2), tag=3, mu=0x00800, s=0x05000, sigma=0x01000 -> o_new_option high one cycle after accept, outputs hold these values; i_core_done with acc1=0x100000, acc2=0x0FFFFF -> next cycle o_res_valid=1, tag=3, price=0x1FFFFF.
- Back-to-back valid held high -> accepts spaced exactly 9 clocks; third request stalls with ready=0 while inflight=2; ready returns the cycle after the first done.
- Two dones, tags 5 then 6, with i_res_ready=0 -> result holds tag 5, o_overrun=1, inflight=0, tag 6 lost.
- i_core_done with inflight=0 -> o_spurious=1, o_res_valid stays 0.
- Max accumulators acc1=acc2=0x7FFFFF -> price=0xFFFFFE (24-bit, no wrap).
- rst_n pulsed low with 2 options outstanding and a result pending -> all outputs 0 immediately, inflight=0; a subsequent done sets o_spurious.
